// File: rtl/wb_hp_pkg.sv
// Shared definitions for the wb_hp Wishbone initiator.
// FSM encoding, response codes and wb_hp register field positions.
package wb_hp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ADDR    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // wb_hp slave register layout
  localparam int HP_VCC        = 0;
  localparam int HP_ALARM_RST  = 1;
  localparam int HP_CTR_RST    = 2;
  localparam int HP_GLITCH_EN  = 3;
  localparam int HP_ALARM      = 4;
  localparam int HP_LATCH      = 5;
  localparam int HP_CTR_LSB    = 6;
  localparam int HP_CTR_MSB    = 13;
  localparam int HP_PN_SEL_LSB = 14;
  localparam int HP_PN_SEL_MSB = 15;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  function automatic logic adr_legal(
    input logic [31:0] adr,
    input logic [31:0] base,
    input logic [31:0] mask
  );
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles and flags the
// last permitted cycle so the FSM can abort on it.
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/wb_hp_initiator.sv
// Single-word Wishbone pipelined initiator with address window
// check and bounded bus cycles, driven by a cmd/rsp handshake.
module wb_hp_initiator
  import wb_hp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_FFF0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_stl_i,
  input  logic [31:0] wbm_dat_i
);

  logic [1:0]  state;
  wb_req_t     req;
  logic [31:0] rdat;
  logic [1:0]  err;
  logic        busy;
  logic        expired;

  assign busy = (state == ST_REQ) || (state == ST_WAIT);

  wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (wb_clk_i),
    .rst_n   (reset_n),
    .clear   (state == ST_IDLE),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      req   <= '0;
      rdat  <= '0;
      err   <= ERR_OK;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            req  <= '{we: cmd_we, adr: cmd_adr, dat: cmd_dat};
            rdat <= '0;
            if (adr_legal(cmd_adr, BASE_ADDRESS, ADDR_MASK)) begin
              state <= ST_REQ;
              err   <= ERR_OK;
            end else begin
              state <= ST_RESP;
              err   <= ERR_ADDR;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          // an ack on the final permitted cycle still completes
          if (wbm_ack_i) begin
            state <= ST_RESP;
            err   <= ERR_OK;
            rdat  <= req.we ? '0 : wbm_dat_i;
          end else if (expired) begin
            state <= ST_RESP;
            err   <= ERR_TIMEOUT;
            rdat  <= '0;
          end else if (state == ST_REQ && !wbm_stl_i) begin
            state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_dat   = rdat;
  assign rsp_err   = err;

  assign wbm_cyc_o = busy;
  assign wbm_stb_o = (state == ST_REQ);
  assign wbm_we_o  = req.we;
  assign wbm_adr_o = req.adr;
  assign wbm_dat_o = req.dat;

endmodule
